// File: rtl/sobel_pkg.sv
// Shared constants, gradient typedef and helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam int NORM_L1  = 0;
  localparam int NORM_MAX = 1;

  // Wide signed container for window arithmetic; stage registers keep only grad_w() bits.
  typedef logic signed [31:0] grad_t;

  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction

  // Clamp an unsigned value to the largest number representable in width bits (width < 32).
  function automatic logic [31:0] saturate(input logic [31:0] value, input int width);
    logic [31:0] limit;
    limit = (32'd1 << width) - 32'd1;
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line delay: circular RAM, read-before-write at a pointer that advances on en.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     ptr;

  // rd_data is the word written DEPTH enables ago, i.e. the same column one line earlier.
  assign rd_data = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: line buffers build the window, stage 1 forms gx/gy, stage 2 forms
// the saturated magnitude and edge bit.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 320,
  parameter int MAG_W  = DATA_W + 3,
  parameter int NORM   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pix,
  input  logic [MAG_W-1:0]  threshold,
  output logic              out_valid,
  output logic [MAG_W-1:0]  out_mag,
  output logic              out_edge,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y
);

  // Valid-only stream, no ready: each in_valid cycle yields exactly one out_valid cycle two
  // clocks later; in_sof is ignored unless in_valid is high; gaps freeze all window state.

  localparam int GW = grad_w(DATA_W);

  logic [15:0] x_q, y_q;
  logic [15:0] px, py;
  logic        border_c;
  logic [15:0] cx_c, cy_c;

  always_comb begin
    px       = in_sof ? 16'd0 : x_q;
    py       = in_sof ? 16'd0 : y_q;
    border_c = (px < 16'd2) || (py < 16'd2);
    cx_c     = (px == 16'd0) ? 16'd0 : px - 16'd1;
    cy_c     = (py == 16'd0) ? 16'd0 : py - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_valid) begin
      if (px == 16'(IMG_W - 1)) begin
        x_q <= '0;
        y_q <= (py == 16'hFFFF) ? py : py + 16'd1;
      end else begin
        x_q <= px + 16'd1;
        y_q <= py;
      end
    end
  end

  // Cascade: lb1 delays the live row by one line, lb0 delays lb1's output by another.
  logic [DATA_W-1:0] row1_pix, row0_pix;

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .reset   (reset),
    .en      (in_valid),
    .wr_data (in_pix),
    .rd_data (row1_pix)
  );

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .reset   (reset),
    .en      (in_valid),
    .wr_data (row1_pix),
    .rd_data (row0_pix)
  );

  // Per row: two registered columns (x-2, x-1) plus the arriving column x form the 3 taps.
  logic [DATA_W-1:0] col_now [3];
  logic [DATA_W-1:0] hist    [3][2];

  assign col_now[0] = row0_pix;
  assign col_now[1] = row1_pix;
  assign col_now[2] = in_pix;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        hist[r][0] <= hist[r][1];
        hist[r][1] <= col_now[r];
      end
    end
  end

  grad_t win [3][3];
  grad_t gx_c, gy_c;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = grad_t'(hist[r][0]);
      win[r][1] = grad_t'(hist[r][1]);
      win[r][2] = grad_t'(col_now[r]);
    end
    gx_c = (win[0][2] + 2 * win[1][2] + win[2][2]) - (win[0][0] + 2 * win[1][0] + win[2][0]);
    gy_c = (win[0][0] + 2 * win[0][1] + win[0][2]) - (win[2][0] + 2 * win[2][1] + win[2][2]);
  end

  logic                 s1_valid;
  logic                 s1_border;
  logic [15:0]          s1_x, s1_y;
  logic signed [GW-1:0] gx_q, gy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b1;
      s1_x      <= '0;
      s1_y      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_border <= border_c;
        s1_x      <= cx_c;
        s1_y      <= cy_c;
        gx_q      <= GW'(gx_c);
        gy_q      <= GW'(gy_c);
      end
    end
  end

  // |g| never reaches -2^(GW-1), so negating within GW bits is exact.
  logic [GW-1:0]    ax, ay, hi, lo;
  logic [31:0]      sum_c;
  logic [MAG_W-1:0] mag_c;

  always_comb begin
    ax    = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay    = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    hi    = (ax > ay) ? ax : ay;
    lo    = (ax > ay) ? ay : ax;
    sum_c = (NORM == NORM_MAX) ? 32'(hi) + 32'(lo >> 1) : 32'(ax) + 32'(ay);
    mag_c = s1_border ? '0 : MAG_W'(saturate(sum_c, MAG_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mag  <= mag_c;
        out_edge <= mag_c > threshold;
        out_x    <= s1_x;
        out_y    <= s1_y;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: three configurations (L1, max-approx, narrow saturating L1) fed the
// same pixel stream and compared against a frame-array reference model.
module tb_sobel_stream;

  localparam int IMG_W = 8;
  localparam int EXP_W = 75;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_sof;
  logic [11:0] in_pix;
  logic [14:0] thr;

  logic        ov [3];
  logic        oe [3];
  logic [15:0] ox [3];
  logic [15:0] oy [3];
  logic [14:0] om0, om1;
  logic [12:0] om2;

  sobel_stream #(.DATA_W(12), .IMG_W(IMG_W), .MAG_W(15), .NORM(0)) u_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .threshold(thr), .out_valid(ov[0]), .out_mag(om0), .out_edge(oe[0]),
    .out_x(ox[0]), .out_y(oy[0])
  );

  sobel_stream #(.DATA_W(12), .IMG_W(IMG_W), .MAG_W(15), .NORM(1)) u_max (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .threshold(thr), .out_valid(ov[1]), .out_mag(om1), .out_edge(oe[1]),
    .out_x(ox[1]), .out_y(oy[1])
  );

  sobel_stream #(.DATA_W(12), .IMG_W(IMG_W), .MAG_W(13), .NORM(0)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .threshold(thr[12:0]), .out_valid(ov[2]), .out_mag(om2), .out_edge(oe[2]),
    .out_x(ox[2]), .out_y(oy[2])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int mx = 0, my = 0;
  int img [4][IMG_W];
  bit exp_v1 = 0, exp_v2 = 0;

  function automatic int model_mag(input int gx, input int gy, input int norm, input int mw);
    int ax, ay, v, lim;
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    if (norm == 0) v = ax + ay;
    else v = ((ax > ay) ? ax : ay) + ((ax > ay) ? ay : ax) / 2;
    lim = (1 << mw) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic int pw(input int py, input int px, input int r, input int c);
    return img[(py + 2 + r) % 4][px - 2 + c];
  endfunction

  task automatic model_pixel(input bit sof, input logic [11:0] pix);
    int px, py, gx, gy, m0, m1, m2, ex, ey;
    px = sof ? 0 : mx;
    py = sof ? 0 : my;
    img[py % 4][px] = int'(pix);
    m0 = 0; m1 = 0; m2 = 0;
    if (px >= 2 && py >= 2) begin
      gx = (pw(py,px,0,2) + 2*pw(py,px,1,2) + pw(py,px,2,2))
         - (pw(py,px,0,0) + 2*pw(py,px,1,0) + pw(py,px,2,0));
      gy = (pw(py,px,0,0) + 2*pw(py,px,0,1) + pw(py,px,0,2))
         - (pw(py,px,2,0) + 2*pw(py,px,2,1) + pw(py,px,2,2));
      m0 = model_mag(gx, gy, 0, 15);
      m1 = model_mag(gx, gy, 1, 15);
      m2 = model_mag(gx, gy, 0, 13);
    end
    ex = (px == 0) ? 0 : px - 1;
    ey = (py == 0) ? 0 : py - 1;
    exp_q.push_back({16'(ex), 16'(ey), 15'(m0), 15'(m1), 13'(m2)});
    mx = px + 1;
    my = py;
    if (mx == IMG_W) begin
      mx = 0;
      if (my != 65535) my = my + 1;
    end
  endtask

  task automatic check_outputs();
    logic [EXP_W-1:0] e;
    int m [3];
    int got_m [3];
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (ov[i] === exp_v2) else begin
        errors++;
        $error("FAIL valid[%0d] got %b want %b", i, ov[i], exp_v2);
      end
    end
    if (exp_v2) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL queue_underflow got size %0d want >0", exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m[0] = int'(e[42:28]);
        m[1] = int'(e[27:13]);
        m[2] = int'(e[12:0]);
        got_m[0] = int'(om0);
        got_m[1] = int'(om1);
        got_m[2] = int'(om2);
        for (int i = 0; i < 3; i++) begin
          checks++;
          assert (got_m[i] === m[i]) else begin
            errors++;
            $error("FAIL mag[%0d] at (%0d,%0d) got %0d want %0d", i, e[74:59], e[58:43], got_m[i], m[i]);
          end
          checks++;
          assert (oe[i] === ((i == 2) ? (m[i] > int'(thr[12:0])) : (m[i] > int'(thr)))) else begin
            errors++;
            $error("FAIL edge[%0d] at (%0d,%0d) got %b mag %0d thr %0d", i, e[74:59], e[58:43], oe[i], m[i], thr);
          end
          checks++;
          assert (ox[i] === e[74:59] && oy[i] === e[58:43]) else begin
            errors++;
            $error("FAIL coord[%0d] got (%0d,%0d) want (%0d,%0d)", i, ox[i], oy[i], e[74:59], e[58:43]);
          end
        end
      end
    end
  endtask

  // driver: apply inputs, advance the model at the sampling edge, check at the falling edge
  task automatic cycle(input bit v, input bit sof, input logic [11:0] pix, input bit rst);
    in_valid = v;
    in_sof   = sof;
    in_pix   = pix;
    reset    = rst;
    @(posedge clk);
    exp_v2 = exp_v1;
    exp_v1 = v && !rst;
    if (rst) begin
      exp_v2 = 0;
      exp_v1 = 0;
      mx = 0;
      my = 0;
      exp_q.delete();
    end else if (v) begin
      model_pixel(sof, pix);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
  endtask

  // kind: 0 random, 1 flat 0x800, 2 vertical step at column 4; thr_fix < 0 means random
  task automatic run_frame(input int kind, input int npix, input int gap_pct,
                           input int sof_at, input int rst_at, input int thr_fix);
    logic [11:0] pix;
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) idle(1);
      if (thr_fix >= 0) thr = 15'(thr_fix);
      else thr = 15'($urandom_range(0, 6000));
      case (kind)
        1:       pix = 12'h800;
        2:       pix = ((i % IMG_W) < 4) ? 12'd0 : 12'd4095;
        default: pix = 12'($urandom);
      endcase
      cycle(1'b1, i == sof_at, pix, i == rst_at);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pix   = '0;
    thr      = '0;
    reset    = 1'b1;
    cycle(1'b0, 1'b0, 12'd0, 1'b1);
    cycle(1'b1, 1'b1, 12'hABC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert (oe[i] === 1'b0 && ox[i] === 16'd0 && oy[i] === 16'd0) else begin
        errors++;
        $error("FAIL reset_state[%0d] got edge %b x %0d y %0d want 0 0 0", i, oe[i], ox[i], oy[i]);
      end
    end
    checks++;
    assert (om0 === 15'd0 && om1 === 15'd0 && om2 === 13'd0) else begin
      errors++;
      $error("FAIL reset_mag got %0d %0d %0d want 0 0 0", om0, om1, om2);
    end

    run_frame(1, 64, 0, 0, -1, 100);
    idle(3);
    run_frame(2, 64, 0, 0, -1, 16379);
    idle(3);
    run_frame(2, 64, 0, 0, -1, 16380);
    idle(3);
    run_frame(0, 64, 40, 0, -1, -1);
    idle(2);
    run_frame(0, 20, 0, 0, -1, -1);
    run_frame(0, 48, 30, 0, -1, -1);
    idle(2);
    run_frame(0, 64, 20, 0, 43, -1);
    idle(2);
    run_frame(0, 64, 25, -1, -1, -1);
    idle(4);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming 3x3 Sobel edge detector for the VGA camera path.
- Accepts one grayscale pixel per valid cycle in raster order.
- Builds the 3x3 window internally from two line buffers.
- Emits, per input pixel, a pipelined gradient magnitude and a thresholded edge bit for the motion-recognition logic.
- Generalises the single-window combinational filter with: parametrised width and line length, a runtime threshold, a selectable magnitude norm, and border handling.

Parameters:
- DATA_W, 12, grayscale pixel width in bits.
- IMG_W, 320, active pixels per line; line-buffer depth.
- MAG_W, DATA_W+3, output magnitude width; results above 2^MAG_W-1 saturate.
- NORM, 0, 0 = L1 (|gx|+|gy|), 1 = max-approx (max + min/2).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, pixel present this cycle.
- in_sof, input, 1, qualifies in_valid; marks pixel (0,0) of a frame.
- in_pix, input, DATA_W, grayscale pixel.
- threshold, input, MAG_W, edge threshold; sampled each cycle at stage 2.
- out_valid, output, 1, result present.
- out_mag, output, MAG_W, saturated gradient magnitude.
- out_edge, output, 1, 1 when out_mag > threshold.
- out_x, output, 16, column of the window centre.
- out_y, output, 16, row of the window centre.

Behaviour:
- Reset: out_valid=0, out_mag=0, out_edge=0, out_x=0, out_y=0. Column/row counters are cleared to 0. Line-buffer contents are not cleared, because border masking makes them don't-care. Reset mid-frame discards all in-flight results.
- Counters: x increments on each in_valid and wraps from IMG_W-1 to 0. y increments on that wrap and saturates at 0xFFFF. When in_valid and in_sof are both high, the pixel is taken as (0,0) and the counters reload accordingly, overriding any count in progress.
- Window: the pixel arriving at (x,y) completes the window centred at (x-1,y-1). Rows come from line buffer 1 (y-1), line buffer 0 (y-2) and the live input (y). Columns are held in a 3-deep shift register per row. Both shift only on in_valid; gaps (in_valid=0) stall all state and do not move the window.
- Pipeline, 2 cycles (in_valid at cycle t gives out_valid at t+2):
  - Stage 1 registers signed gx and gy, width DATA_W+3 each, computed exactly. gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20); gy = (p00 + 2*p01 + p02) - (p20 + 2*p21 + p22). Row index 0 is the top row (y-2).
  - Stage 2 registers the absolute values, combines them per NORM, saturates to MAG_W, and compares against threshold with a strict >.
- Border: if x<2 or y<2 at input, the output still issues with out_valid=1 but with out_mag=0 and out_edge=0 (threshold is unsigned, so 0 > threshold never holds). out_x/out_y then carry the centre coordinate. When x<1 or y<1 the centre is negative and out_x/out_y are 0.
- Simultaneous events: in_sof without in_valid is ignored. Reset has priority over all other inputs.
- No backpressure: the downstream consumer must accept every result.

Decomposition:
- sobel_pkg holds: the NORM_L1 and NORM_MAX constants, the function grad_w(DATA_W) returning DATA_W+3, a saturate function, and a typedef for the signed gradient.
- One sub-module, sobel_line_buffer: a single-port circular RAM of IMG_W×DATA_W with a read-before-write address pointer, advanced on an enable input. The top level instantiates it twice in cascade.

Test Plan:
- Flat frame (IMG_W=8, DATA_W=12, all pixels 0x800, threshold=100) -> every out_mag=0 and out_edge=0. out_valid is high exactly 2 cycles after each in_valid, giving 64 outputs.
- Vertical step (columns 0-3 = 0, columns 4-7 = 4095, threshold=2500) -> at centre x=3 and x=4, for y≥1, out_mag=16380 and out_edge=1. All other interior columns give out_mag=0. Rows y<1 are masked to 0.
- Saturation (MAG_W=13, window 0/4095 diagonal corner, NORM=0) -> |gx|+|gy| = 16380 exceeds 8191, so out_mag=8191.
- NORM=1 with gx=400, gy=-200 -> out_mag = 400 + 100 = 500. Threshold=500 gives out_edge=0; threshold=499 gives out_edge=1.
- Stall and restart: random in_valid gaps give outputs identical to a gap-free run. A new in_sof asserted mid-line restarts coordinates at (0,0), and the next two rows are border-masked.
- reset asserted during row 5 -> out_valid=0 on the next cycle, with no stale results afterwards. The first frame after reset matches the golden model.
